// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction-fetch sequencer between PC register, instruction bus
//             and ID. Optional bus timeout enabled by macro FETCH_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic        pc_bflag,
    output logic [31:0] pc_baddr,
    output logic        pc_flush,
    output logic [31:0] pc_new_pc,
    input  logic        br_flag,
    input  logic [31:0] br_addr,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc,
    input  logic        id_stall,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_adel,
    output logic        inst_ibe
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic        r_br_pend;
    logic [31:0] r_br_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_adel;
    logic        r_ibe;

    logic        w_mis;
    logic        w_tmo;
    logic        w_done;
    logic        w_adv;
    logic        w_load;

    assign w_mis     = |pc[1:0];
    assign w_done    = w_mis | ibus_ack | w_tmo;
    assign pc_flush  = exc_flush;
    assign pc_new_pc = exc_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int c_WAIT_W = 16;
    logic [c_WAIT_W-1:0] r_wait;

    // Counts cycles of an unanswered request; the compare cycle drops ibus_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (ibus_req && !ibus_ack) begin
            r_wait <= r_wait + c_WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    assign w_tmo = (r_wait == c_WAIT_W'(TIMEOUT_CYCLES));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_load      = 1'b0;
        ibus_req    = 1'b0;
        ibus_addr   = r_addr;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                ibus_req  = !w_mis && !w_tmo;
                ibus_addr = pc;
                if (exc_flush) begin
                    w_state_nxt = w_done ? S_REQ : S_DRAIN;
                end else if (w_done) begin
                    w_load = 1'b1;
                    if (id_stall) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (exc_flush) begin
                    w_state_nxt = S_REQ;
                end else if (!id_stall) begin
                    w_adv       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                // Killed fetch: keep the original request up until the bus answers.
                ibus_req = !w_tmo;
                if (ibus_ack || w_tmo) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        pc_stall = !w_adv;
        pc_bflag = w_adv && (r_br_pend || br_flag);
        pc_baddr = pc_bflag ? (r_br_pend ? r_br_addr : br_addr) : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'd0;
            r_br_pend    <= 1'b0;
            r_br_addr    <= 32'd0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_adel       <= 1'b0;
            r_ibe        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_REQ) begin
                r_addr <= pc;
            end
            // Branch seen while the PC is held targets the word after the delay slot.
            if (exc_flush || pc_bflag) begin
                r_br_pend <= 1'b0;
            end else if (br_flag) begin
                r_br_pend <= 1'b1;
                r_br_addr <= br_addr;
            end
            if (exc_flush) begin
                r_inst_valid <= 1'b0;
            end else if (w_load) begin
                r_inst_valid <= 1'b1;
            end else if (!id_stall) begin
                r_inst_valid <= 1'b0;
            end
            if (w_load) begin
                r_inst    <= (ibus_ack && !w_mis) ? ibus_rdata : 32'd0;
                r_inst_pc <= pc;
                r_adel    <= w_mis;
                r_ibe     <= !w_mis && !ibus_ack && w_tmo;
            end
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_adel  = r_adel;
    assign inst_ibe   = r_ibe;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Directed cycle-by-cycle vector bench for fetch_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    localparam logic [31:0] B = 32'hBFC0_0000;
    localparam logic [31:0] T = 32'h8000_0100;
    localparam logic [31:0] E = 32'h8000_0180;
    localparam logic [31:0] M = 32'h8000_0002;
    localparam logic [31:0] F = 32'h8000_0200;
    localparam logic [31:0] G = 32'h8000_0400;
    localparam logic [31:0] H = 32'h8000_0300;
    localparam logic [31:0] J = 32'h8000_0500;
    localparam logic [31:0] K = 32'h8000_0600;

    logic        clk, rst;
    logic [31:0] pc, br_addr, exc_pc, ibus_rdata;
    logic        br_flag, exc_flush, id_stall, ibus_ack;
    logic        pc_stall, pc_bflag, pc_flush, ibus_req, inst_valid, inst_adel, inst_ibe;
    logic [31:0] pc_baddr, pc_new_pc, ibus_addr, inst, inst_pc;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .pc_stall(pc_stall), .pc_bflag(pc_bflag), .pc_baddr(pc_baddr),
        .pc_flush(pc_flush), .pc_new_pc(pc_new_pc),
        .br_flag(br_flag), .br_addr(br_addr),
        .exc_flush(exc_flush), .exc_pc(exc_pc), .id_stall(id_stall),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_adel(inst_adel), .inst_ibe(inst_ibe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        br;
        logic [31:0] ba;
        logic        exc;
        logic [31:0] ea;
        logic        stl;
        logic        ack;
        logic [31:0] rd;
        logic        e_stall;
        logic        e_bflag;
        logic [31:0] e_baddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_adel;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(
        input logic [31:0] p, input logic br, input logic [31:0] ba,
        input logic exc, input logic [31:0] ea, input logic stl,
        input logic ack, input logic [31:0] rd,
        input logic es, input logic eb, input logic [31:0] eba,
        input logic erq, input logic [31:0] ead, input logic ev,
        input logic [31:0] ei, input logic [31:0] eip, input logic eadl);
        vec_t v;
        v = '{p, br, ba, exc, ea, stl, ack, rd, es, eb, eba, erq, ead, ev, ei, eip, eadl};
        return v;
    endfunction

    function automatic logic [166:0] actual();
        return {pc_stall, pc_bflag, pc_baddr, pc_flush, pc_new_pc, ibus_req, ibus_addr,
                inst_valid, inst, inst_pc, inst_adel, inst_ibe};
    endfunction

    function automatic logic [166:0] expect_of(input vec_t v);
        return {v.e_stall, v.e_bflag, v.e_baddr, v.exc, v.ea, v.e_req, v.e_addr,
                v.e_vld, v.e_inst, v.e_ipc, v.e_adel, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [166:0] act, input logic [166:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drv(input vec_t v);
        pc = v.pc; br_flag = v.br; br_addr = v.ba; exc_flush = v.exc; exc_pc = v.ea;
        id_stall = v.stl; ibus_ack = v.ack; ibus_rdata = v.rd;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        drv(v);
        @(negedge clk);
        chk(name, actual(), expect_of(v));
        @(posedge clk); #1;
    endtask

    initial begin
        // pc, br, ba, exc, ea, stl, ack, rd | stall, bflag, baddr, req, addr, vld, inst, ipc, adel
        tbl[0]  = mk(B,     0,0, 0,0, 0, 0,0,             1,0,0, 0,0,     0,0,             0,     0);
        tbl[1]  = mk(B,     0,0, 0,0, 0, 1,32'h24010001,  0,0,0, 1,B,     0,0,             0,     0);
        tbl[2]  = mk(B+4,   0,0, 0,0, 0, 1,32'h24010002,  0,0,0, 1,B+4,   1,32'h24010001,  B,     0);
        tbl[3]  = mk(B+8,   1,T, 0,0, 0, 0,0,             1,0,0, 1,B+8,   1,32'h24010002,  B+4,   0);
        tbl[4]  = mk(B+8,   0,0, 0,0, 0, 0,0,             1,0,0, 1,B+8,   0,32'h24010002,  B+4,   0);
        tbl[5]  = mk(B+8,   0,0, 0,0, 0, 0,0,             1,0,0, 1,B+8,   0,32'h24010002,  B+4,   0);
        tbl[6]  = mk(B+8,   0,0, 0,0, 0, 1,32'h24010003,  0,1,T, 1,B+8,   0,32'h24010002,  B+4,   0);
        tbl[7]  = mk(T,     0,0, 0,0, 0, 0,0,             1,0,0, 1,T,     1,32'h24010003,  B+8,   0);
        tbl[8]  = mk(T,     0,0, 1,E, 0, 0,0,             1,0,0, 1,T,     0,32'h24010003,  B+8,   0);
        tbl[9]  = mk(E,     0,0, 0,0, 0, 0,0,             1,0,0, 1,T,     0,32'h24010003,  B+8,   0);
        tbl[10] = mk(E,     0,0, 0,0, 0, 0,0,             1,0,0, 1,T,     0,32'h24010003,  B+8,   0);
        tbl[11] = mk(E,     0,0, 0,0, 0, 1,32'hDEADBEEF,  1,0,0, 1,T,     0,32'h24010003,  B+8,   0);
        tbl[12] = mk(E,     0,0, 0,0, 0, 1,32'h24010004,  0,0,0, 1,E,     0,32'h24010003,  B+8,   0);
        tbl[13] = mk(E+4,   0,0, 0,0, 1, 1,32'h24010005,  1,0,0, 1,E+4,   1,32'h24010004,  E,     0);
        for (int i = 14; i < 18; i++)
            tbl[i] = mk(E+4, 0,0, 0,0, 1, 0,0,            1,0,0, 0,E+4,   1,32'h24010005,  E+4,   0);
        tbl[18] = mk(E+4,   1,M, 0,0, 0, 0,0,             0,1,M, 0,E+4,   1,32'h24010005,  E+4,   0);
        tbl[19] = mk(M,     0,0, 0,0, 0, 0,0,             0,0,0, 0,M,     0,32'h24010005,  E+4,   0);
        tbl[20] = mk(M+4,   0,0, 1,F, 0, 0,0,             1,0,0, 0,M+4,   1,0,             M,     1);
        tbl[21] = mk(F,     0,0, 0,0, 0, 1,32'h24010006,  0,0,0, 1,F,     0,0,             M,     1);
        tbl[22] = mk(F+4,   0,0, 0,0, 0, 0,0,             1,0,0, 1,F+4,   1,32'h24010006,  F,     0);
        tbl[23] = mk(F+4,   1,G, 1,H, 0, 1,32'h24010007,  1,0,0, 1,F+4,   0,32'h24010006,  F,     0);
        tbl[24] = mk(H,     0,0, 0,0, 0, 1,32'h24010008,  0,0,0, 1,H,     0,32'h24010006,  F,     0);
        tbl[25] = mk(H+4,   0,0, 0,0, 0, 0,0,             1,0,0, 1,H+4,   1,32'h24010008,  H,     0);

        rst = 1'b1;
        drv(mk(B, 0,0, 0,0, 0, 0,0, 0,0,0, 0,0, 0,0,0,0));
        @(negedge clk);
        chk("reset", actual(), {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                                1'b0, 32'd0, 32'd0, 1'b0, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 26; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Second flush while draining only redirects the PC; the drain continues.
        run_vec(mk(H+4, 0,0, 1,J, 0, 0,0,            1,0,0, 1,H+4, 0,32'h24010008, H, 0), "dflush_req");
        run_vec(mk(J,   0,0, 1,K, 0, 0,0,            1,0,0, 1,H+4, 0,32'h24010008, H, 0), "dflush_drain");
        run_vec(mk(K,   0,0, 0,0, 0, 1,32'hBAD0BAD0, 1,0,0, 1,H+4, 0,32'h24010008, H, 0), "dflush_ack");
        run_vec(mk(K,   0,0, 0,0, 0, 1,32'h24010009, 0,0,0, 1,K,   0,32'h24010008, H, 0), "dflush_refetch");
        run_vec(mk(K+4, 0,0, 0,0, 0, 0,0,            1,0,0, 1,K+4, 1,32'h24010009, K, 0), "dflush_deliver");

`ifdef FETCH_TIMEOUT_EN
        // Request at K+4 has waited one cycle; seven more with ibus_req held high.
        for (int i = 0; i < 7; i++) begin
            drv(mk(K+4, 0,0, 0,0, 0, 0,0, 0,0,0, 0,0, 0,0,0,0));
            @(negedge clk);
            chk($sformatf("tmo_wait%0d", i), {166'd0, ibus_req}, {166'd0, 1'b1});
            @(posedge clk); #1;
        end
        drv(mk(K+4, 0,0, 0,0, 0, 0,0, 0,0,0, 0,0, 0,0,0,0));
        @(negedge clk);
        chk("tmo_drop", {164'd0, ibus_req, pc_stall, ibus_addr == K+4},
                        {164'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        drv(mk(K+8, 0,0, 0,0, 0, 0,0, 0,0,0, 0,0, 0,0,0,0));
        @(negedge clk);
        chk("tmo_ibe", {101'd0, inst_valid, inst_ibe, inst_adel, inst, inst_pc},
                       {101'd0, 1'b1, 1'b1, 1'b0, 32'd0, K+4});
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
